// File: rtl/uart_sram_pkg.sv
// Shared types for the UART <-> SRAM burst bridge: FSM states, strobe levels, word geometry.
package uart_sram_pkg;

  typedef enum logic [3:0] {
    IDLE, RX_WAIT, RX_STROBE, RX_LATCH, SRAM_WR, SRAM_RD, TX_LAUNCH, TX_BYTE, DONE
  } state_t;

  typedef enum logic [2:0] {
    TX_IDLE, TX_LOAD, TX_STROBE, TX_TBRE, TX_TSRE
  } tx_state_t;

  localparam logic STB_ON  = 1'b0;
  localparam logic STB_OFF = 1'b1;

  function automatic int bytes_per_word(input int data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/uart_byte_tx.sv
// One UART byte write: load/strobe, then wait for the holding and shift registers to drain.
module uart_byte_tx
  import uart_sram_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] data,
  input  logic       tbre,
  input  logic       tsre,
  output logic       wrn,
  output logic [7:0] dq,
  output logic       oe,
  output logic       done
);
  tx_state_t st;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st   <= TX_IDLE;
      wrn  <= STB_OFF;
      dq   <= '0;
      oe   <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      case (st)
        TX_IDLE: if (start) begin
          st  <= TX_LOAD;
          dq  <= data;
          oe  <= 1'b1;
          wrn <= STB_ON;
        end
        // data stays driven through the strobe-release cycle for hold time
        TX_LOAD: begin
          wrn <= STB_OFF;
          st  <= TX_STROBE;
        end
        TX_STROBE: begin
          oe <= 1'b0;
          dq <= '0;
          st <= TX_TBRE;
        end
        TX_TBRE: if (tbre) st <= TX_TSRE;
        TX_TSRE: if (tsre) begin
          st   <= TX_IDLE;
          done <= 1'b1;
        end
        default: st <= TX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/uart_sram_burst_bridge.sv
// UART burst -> SRAM words -> read-back -> UART echo with shadow-compare error count.
// Optional UART_SRAM_CHECKSUM_EN appends an 8-bit additive checksum byte to the echo.
module uart_sram_burst_bridge
  import uart_sram_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 20,
  parameter int LEN_W     = 8,
  parameter int WR_CYCLES = 2,
  parameter int RD_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]  len,
  output logic              busy,
  output logic              done,
  output logic [LEN_W-1:0]  err_cnt,
  input  logic [DATA_W-1:0] dq_i,
  output logic [DATA_W-1:0] dq_o,
  output logic              dq_oe,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_ce_n,
  output logic              ram_oe_n,
  output logic              ram_we_n,
  output logic              uart_rdn,
  output logic              uart_wrn,
  input  logic              uart_dataready,
  input  logic              uart_tbre,
  input  logic              uart_tsre
);
  localparam int BPW  = bytes_per_word(DATA_W);
  localparam int LW   = (BPW > 1) ? $clog2(BPW) : 1;
  localparam int CMAX = (WR_CYCLES > RD_CYCLES) ? WR_CYCLES : RD_CYCLES;
  localparam int CW   = $clog2(CMAX + 1);

  state_t            state;
  logic [ADDR_W-1:0] base_r;
  logic [LEN_W-1:0]  len_r, idx;
  logic [LW-1:0]     lane;
  logic [CW-1:0]     cyc;
  logic [DATA_W-1:0] pack, rd_word, wr_dq;
  logic              wr_oe, tx_start, tx_done, tx_oe;
  logic [7:0]        tx_byte, tx_dq, rd_byte, tail_byte;
  logic              tail_pending, last;
  logic [7:0]        shadow [2**LEN_W];

  assign rd_byte = rd_word[lane*8 +: 8];
  assign last    = (idx == len_r - LEN_W'(1));
  assign dq_o    = wr_dq | DATA_W'(tx_dq);
  assign dq_oe   = wr_oe | tx_oe;

  always_ff @(posedge clk)
    if (state == RX_STROBE) shadow[idx] <= dq_i[7:0];

`ifdef UART_SRAM_CHECKSUM_EN
  logic [7:0] csum;
  logic       csum_sent;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      csum      <= '0;
      csum_sent <= 1'b0;
    end else if (state == IDLE && start) begin
      csum      <= '0;
      csum_sent <= 1'b0;
    end else begin
      if (state == RX_STROBE) csum <= csum + dq_i[7:0];
      if (state == TX_BYTE && tx_done && last) csum_sent <= 1'b1;
    end
  end
  assign tail_pending = !csum_sent;
  assign tail_byte    = csum;
`else
  assign tail_pending = 1'b0;
  assign tail_byte    = 8'h00;
`endif

  uart_byte_tx u_tx (
    .clk  (clk),
    .rst  (rst),
    .start(tx_start),
    .data (tx_byte),
    .tbre (uart_tbre),
    .tsre (uart_tsre),
    .wrn  (uart_wrn),
    .dq   (tx_dq),
    .oe   (tx_oe),
    .done (tx_done)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      busy <= 1'b0; done <= 1'b0; err_cnt <= '0;
      ram_addr <= '0; base_r <= '0; len_r <= '0; idx <= '0; lane <= '0; cyc <= '0;
      ram_ce_n <= STB_OFF; ram_oe_n <= STB_OFF; ram_we_n <= STB_OFF; uart_rdn <= STB_OFF;
      pack <= '0; rd_word <= '0; wr_dq <= '0; wr_oe <= 1'b0;
      tx_start <= 1'b0; tx_byte <= '0;
    end else begin
      done     <= 1'b0;
      tx_start <= 1'b0;
      case (state)
        IDLE: if (start) begin
          busy <= 1'b1; err_cnt <= '0;
          base_r <= base_addr; ram_addr <= base_addr; len_r <= len;
          idx <= '0; lane <= '0; pack <= '0;
          if (len == '0) begin
            done  <= 1'b1;
            state <= DONE;
          end else state <= RX_WAIT;
        end
        RX_WAIT: if (uart_dataready) begin
          uart_rdn <= STB_ON;
          state    <= RX_STROBE;
        end
        // byte is taken while rdn is still low so the UART is still driving it
        RX_STROBE: begin
          pack[lane*8 +: 8] <= dq_i[7:0];
          uart_rdn <= STB_OFF;
          idx   <= idx + LEN_W'(1);
          lane  <= (lane == LW'(BPW-1)) ? '0 : lane + LW'(1);
          state <= RX_LATCH;
        end
        RX_LATCH: if (lane == '0 || idx == len_r) begin
          ram_ce_n <= STB_ON; ram_we_n <= STB_ON;
          wr_oe <= 1'b1; wr_dq <= pack; cyc <= '0;
          state <= SRAM_WR;
        end else state <= RX_WAIT;
        SRAM_WR: begin
          if (cyc == CW'(WR_CYCLES-1)) begin
            ram_ce_n <= STB_OFF; ram_we_n <= STB_OFF; wr_oe <= 1'b0;
            cyc <= cyc + CW'(1);
          end else if (cyc == CW'(WR_CYCLES)) begin
            wr_dq <= '0; pack <= '0;
            ram_addr <= ram_addr + ADDR_W'(1);
            if (idx != len_r) state <= RX_WAIT;
            else begin
              ram_addr <= base_r; idx <= '0; lane <= '0; cyc <= '0;
              ram_ce_n <= STB_ON; ram_oe_n <= STB_ON;
              state <= SRAM_RD;
            end
          end else cyc <= cyc + CW'(1);
        end
        SRAM_RD: if (cyc == CW'(RD_CYCLES-1)) begin
          rd_word  <= dq_i;
          ram_ce_n <= STB_OFF; ram_oe_n <= STB_OFF;
          state    <= TX_LAUNCH;
        end else cyc <= cyc + CW'(1);
        TX_LAUNCH: begin
          tx_byte  <= rd_byte;
          tx_start <= 1'b1;
          if (rd_byte != shadow[idx] && err_cnt != '1) err_cnt <= err_cnt + LEN_W'(1);
          state <= TX_BYTE;
        end
        TX_BYTE: if (tx_done) begin
          if (last) begin
            if (tail_pending) begin
              tx_byte  <= tail_byte;
              tx_start <= 1'b1;
            end else begin
              done  <= 1'b1;
              state <= DONE;
            end
          end else if (lane == LW'(BPW-1)) begin
            idx <= idx + LEN_W'(1); lane <= '0; cyc <= '0;
            ram_addr <= ram_addr + ADDR_W'(1);
            ram_ce_n <= STB_ON; ram_oe_n <= STB_ON;
            state <= SRAM_RD;
          end else begin
            idx <= idx + LEN_W'(1); lane <= lane + LW'(1);
            state <= TX_LAUNCH;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_sram_burst_bridge.sv
// Randomized bench: UART/SRAM bus models plus a byte-list reference of words, echo and error count.
module tb_uart_sram_burst_bridge;
  logic        clk = 0, rst = 0, start = 0;
  logic [19:0] base_addr = '0;
  logic [7:0]  len = '0;
  logic        busy, done;
  logic [7:0]  err_cnt;
  logic [31:0] dq_i = '0, dq_o;
  logic        dq_oe;
  logic [19:0] ram_addr;
  logic        ram_ce_n, ram_oe_n, ram_we_n, uart_rdn, uart_wrn;
  logic        uart_dataready = 0, uart_tbre = 0, uart_tsre = 0;

  uart_sram_burst_bridge dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .len(len),
    .busy(busy), .done(done), .err_cnt(err_cnt),
    .dq_i(dq_i), .dq_o(dq_o), .dq_oe(dq_oe), .ram_addr(ram_addr),
    .ram_ce_n(ram_ce_n), .ram_oe_n(ram_oe_n), .ram_we_n(ram_we_n),
    .uart_rdn(uart_rdn), .uart_wrn(uart_wrn),
    .uart_dataready(uart_dataready), .uart_tbre(uart_tbre), .uart_tsre(uart_tsre)
  );

  always #5 clk = ~clk;

  int n_vec = 0, n_err = 0;
  logic [31:0] mem [int];
  logic [7:0]  rxq [$], txq [$], bq [$];
  int   done_cnt = 0, wr_cnt = 0, viol = 0;
  bit   corrupt_en = 0;
  logic prev_we = 1, prev_rdn = 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // bus / UART / SRAM models, all evaluated away from the active edge
  always @(negedge clk) begin
    logic [31:0] rv;
    if (!ram_ce_n && !ram_we_n) begin
      if (prev_we) wr_cnt++;
      mem[int'(ram_addr)] = dq_o;
      if (!dq_oe) viol++;
    end
    if (dq_oe && (!ram_oe_n || !uart_rdn)) viol++;
    if (!uart_wrn) begin
      txq.push_back(dq_o[7:0]);
      if (!dq_oe) viol++;
    end
    if (done) done_cnt++;
    if (uart_rdn && !prev_rdn && rxq.size() > 0) void'(rxq.pop_front());
    prev_we  = ram_we_n;
    prev_rdn = uart_rdn;
    if (!uart_rdn) dq_i = {$urandom_range(0, 32'hFFFFFF), (rxq.size() > 0) ? rxq[0] : 8'h00};
    else if (!ram_ce_n && !ram_oe_n) begin
      rv = mem.exists(int'(ram_addr)) ? mem[int'(ram_addr)] : 32'h0;
      dq_i = corrupt_en ? (rv ^ 32'h00FF_0000) : rv;
    end else dq_i = 32'hA5A5_A5A5;
    uart_dataready = (rxq.size() > 0) && ($urandom_range(0, 2) != 0);
    uart_tbre = ($urandom_range(0, 3) != 0);
    uart_tsre = ($urandom_range(0, 3) != 0);
  end

  // sends bq[0..n-1] as one burst and checks SRAM image, echo, err_cnt, done
  task automatic run_burst(input logic [19:0] base, input int n, input bit corrupt, input bit poke);
    logic [31:0] exp_mem [int];
    logic [7:0]  exp_tx [$];
    logic [31:0] w;
    logic [7:0]  sum = 0;
    int exp_err = 0, cyc = 0, a;
    mem.delete(); txq.delete(); rxq.delete();
    done_cnt = 0; wr_cnt = 0; corrupt_en = corrupt;
    for (int k = 0; k < n; k++) begin
      a = (int'(base) + k / 4) % (1 << 20);
      rxq.push_back(bq[k]);
      w = exp_mem.exists(a) ? exp_mem[a] : 32'h0;
      w[(k % 4) * 8 +: 8] = bq[k];
      exp_mem[a] = w;
      sum += bq[k];
      if (corrupt && (k % 4) == 2) begin exp_tx.push_back(bq[k] ^ 8'hFF); exp_err++; end
      else exp_tx.push_back(bq[k]);
    end
`ifdef UART_SRAM_CHECKSUM_EN
    if (n > 0) exp_tx.push_back(sum);
`endif
    if (exp_err > 255) exp_err = 255;
    @(negedge clk); start = 1; base_addr = base; len = 8'(n);
    @(negedge clk); start = 0; base_addr = $urandom; len = 8'($urandom);
    while (busy && cyc < 30000) begin
      @(negedge clk); cyc++;
      start = (poke && cyc == 7);
    end
    start = 0;
    chk("finish_in_time", {63'd0, cyc < 30000}, 64'd1);
    chk("done_pulses", done_cnt, 1);
    chk("err_cnt", err_cnt, exp_err);
    chk("echo_len", txq.size(), exp_tx.size());
    for (int i = 0; i < exp_tx.size(); i++)
      chk($sformatf("echo[%0d]", i), (i < txq.size()) ? {56'd0, txq[i]} : 64'hDEAD, exp_tx[i]);
    chk("word_writes", wr_cnt, (n + 3) / 4);
    foreach (exp_mem[k])
      chk($sformatf("sram[%05h]", k), mem.exists(k) ? {32'd0, mem[k]} : 64'hDEAD, exp_mem[k]);
  endtask

  task automatic fill(input int n);
    bq.delete();
    for (int i = 0; i < n; i++) bq.push_back(8'($urandom));
  endtask

  initial begin
    int found;
    #1 rst = 1;
    #3;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err_cnt", err_cnt, 0);
    chk("rst_dq_o", dq_o, 0);
    chk("rst_dq_oe", dq_oe, 0);
    chk("rst_ram_addr", ram_addr, 0);
    chk("rst_strobes", {ram_ce_n, ram_oe_n, ram_we_n, uart_rdn, uart_wrn}, 5'b11111);
    @(negedge clk); @(negedge clk); rst = 0;

    bq = '{8'h11, 8'h22, 8'h33, 8'h44};
    run_burst(20'h00010, 4, 0, 0);
    chk("word_0x10", mem.exists(16) ? {32'd0, mem[16]} : 64'hDEAD, 32'h4433_2211);

    fill(5);
    run_burst(20'($urandom), 5, 0, 1);

    fill(4);
    run_burst(20'h00200, 4, 1, 0);

    fill(8);
    run_burst(20'hFFFFF, 8, 0, 0);
    chk("wrap_word", mem.exists(0) ? 64'd1 : 64'd0, 1);

    bq = '{8'hF0, 8'h20};
    run_burst(20'h00040, 2, 0, 0);

    bq.delete();
    run_burst(20'h00100, 0, 0, 0);

    // reset in the middle of an SRAM write
    fill(4); rxq.delete(); foreach (bq[i]) rxq.push_back(bq[i]);
    @(negedge clk); start = 1; base_addr = 20'h00300; len = 8'd4;
    @(negedge clk); start = 0;
    found = 0;
    for (int i = 0; i < 2000 && !found; i++) begin
      @(negedge clk);
      if (!ram_we_n) found = 1;
    end
    chk("reached_sram_wr", found, 1);
    #2 rst = 1;
    #1;
    chk("midrst_strobes", {ram_ce_n, ram_oe_n, ram_we_n, uart_rdn, uart_wrn}, 5'b11111);
    chk("midrst_dq_oe", dq_oe, 0);
    chk("midrst_busy", busy, 0);
    @(negedge clk); rst = 0;

    fill(6);
    run_burst(20'h00300, 6, 0, 0);

    for (int t = 0; t < 6; t++) begin
      int n = $urandom_range(1, 24);
      fill(n);
      run_burst(20'($urandom), n, bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)));
    end

    chk("bus_conflicts", viol, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/uart_sram_burst_bridge.md
# uart_sram_burst_bridge

Parametrised bridge between the board UART controller and the asynchronous base SRAM, sharing one data bus. It receives a burst of LEN bytes from the UART, packs them into DATA_W-bit words, and writes them to consecutive SRAM addresses from a base address. It then reads the words back and retransmits every byte over the UART as a loopback integrity check. It sits between the top-level pin wrapper and the board test logic.

## Interface
- DATA_W, 32: SRAM word width; multiple of 8.
- ADDR_W, 20: SRAM address width.
- LEN_W, 8: width of burst length in bytes.
- WR_CYCLES, 2: cycles we_n held low per SRAM write (>=1).
- RD_CYCLES, 2: cycles oe_n held low before SRAM read data is sampled (>=1).
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  one-cycle pulse; accepted only in IDLE.
- base_addr  in  ADDR_W  first word address, sampled on start.
- len  in  LEN_W  burst length in bytes, sampled on start; 0 means go straight to DONE.
- busy  out  1  high whenever state != IDLE.
- done  out  1  one-cycle pulse on entering DONE.
- err_cnt  out  LEN_W  count of read-back mismatches in the last burst.
- dq_i  in  DATA_W  shared bus input.
- dq_o  out  DATA_W  shared bus drive value.
- dq_oe  out  1  bus drive enable; the pad wrapper tristates when low.
- ram_addr  out  ADDR_W  SRAM address.
- ram_ce_n, ram_oe_n, ram_we_n  out  1 each  SRAM strobes.
- uart_rdn, uart_wrn  out  1  UART strobes, active-low.
- uart_dataready, uart_tbre, uart_tsre  in  1  UART status.

## Operation
- Reset values:
  - busy=0, done=0, err_cnt=0, dq_o=0, dq_oe=0, ram_addr=0.
  - All SRAM and UART strobes = 1.
  - State = IDLE.
- Byte packing is little-endian: byte k of a burst lands in word base_addr + k/(DATA_W/8), lane k%(DATA_W/8).
- A partial final word is written with unused lanes zero.
- The receive path keeps a shadow copy of each byte in a LEN-deep register buffer; read-back compares against it.
- State sequence:
  - IDLE -> RX_WAIT on start.
  - RX_WAIT: wait for uart_dataready=1 -> RX_STROBE.
  - RX_STROBE: uart_rdn=0, dq_oe=0 -> RX_LATCH.
  - RX_LATCH: capture dq_i[7:0] into the pack register; uart_rdn=1.
  - From RX_LATCH:
    - if the word is full or this is the last byte -> SRAM_WR;
    - otherwise -> RX_WAIT.
  - SRAM_WR: ce_n=0, we_n=0, dq_oe=1 for WR_CYCLES, then we_n=1, ce_n=1, dq_oe=0 (one hold cycle).
  - From SRAM_WR, address increments:
    - if bytes remain -> RX_WAIT;
    - otherwise -> SRAM_RD at base_addr.
  - SRAM_RD: ce_n=0, oe_n=0 for RD_CYCLES; sample dq_i on the last cycle; deassert -> TX_LOAD.
  - TX_LOAD: dq_o[7:0]=byte, dq_oe=1, uart_wrn=0 for one cycle -> TX_STROBE.
  - TX_STROBE: uart_wrn=1.
  - TX_TBRE: wait uart_tbre=1.
  - TX_TSRE: wait uart_tsre=1.
  - After TX_TSRE:
    - next lane of the same word -> TX_LOAD;
    - otherwise next word -> SRAM_RD;
    - after the final byte -> DONE.
  - DONE: pulse done -> IDLE.
- Mismatch rule: a read-back byte that differs from its shadow copy increments err_cnt, which saturates at all-ones.
- err_cnt clears on start.
- Boundaries:
  - start while busy is ignored.
  - ram_addr wraps modulo 2^ADDR_W.
  - dq_oe is never high while ram_oe_n=0 or uart_rdn=0.
  - rst mid-burst returns all strobes high within the same edge; no partial write completes.

## Timing
- Per byte received: 3 cycles minimum after dataready.
- Per word write: WR_CYCLES+1 cycles.
- Per word read: RD_CYCLES+1 cycles.
- Per byte transmitted: 4 cycles minimum plus UART wait.
- All outputs are registered; strobes change only on the rising edge of clk.

## Configuration
- UART_SRAM_CHECKSUM_EN defined:
  - An 8-bit additive checksum of the received bytes is transmitted as one extra byte after the last echoed byte (through TX_LOAD..TX_TSRE) before DONE.
  - The checksum is not stored in SRAM.
- Undefined: no extra byte; DONE follows the last echoed byte.

## Structure
- Shared package `uart_sram_pkg`: state enumeration, strobe-level constants, bytes-per-word helper.
- One natural sub-module: `uart_byte_tx`, containing the TX_LOAD..TX_TSRE handshake with a start/ready interface, reused by the checksum path.

## Test plan
- len=4, bytes 11,22,33,44, base 0x00010: one SRAM word 0x44332211 at 0x00010; echo 11 22 33 44; err_cnt=0; one done pulse.
- len=5: second word 0x00000055 at base+1; five bytes echoed.
- SRAM model corrupts lane 2 on read: err_cnt=1; echo shows the corrupted byte.
- Base 0xFFFFF, len=8: second word written at 0x00000.
- rst asserted during SRAM_WR: all strobes high, dq_oe=0, busy=0 immediately; a following start runs a clean burst.
- Checksum build, bytes 0xF0, 0x20: extra transmitted byte 0x10; without the macro, no extra byte is sent.
